// File: rtl/csa_pkg.sv
// Shared types and elaboration-time helpers for the carry-save reduction engine.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    ADD,
    DONE
  } csa_state_t;

  // Operand count remaining after one 3:2 layer.
  function automatic int unsigned csa_next(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  // Number of 3:2 layers needed to bring n operands down to two.
  function automatic int unsigned csa_layers(input int unsigned n);
    int unsigned cur;
    int unsigned l;
    cur = n;
    l   = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (cur > 2) begin
        cur = csa_next(cur);
        l++;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/csa_layer.sv
// One combinational 3:2 carry-save layer over the first n_i of N slots.
module csa_layer #(
  parameter int unsigned N  = 32,
  parameter int unsigned OW = 69
) (
  input  logic [N-1:0][OW-1:0]       slots_i,
  input  logic [$clog2(N+1)-1:0]     n_i,
  output logic [N-1:0][OW-1:0]       slots_o
);

  always_comb begin
    int unsigned n;
    int unsigned ntri;
    int unsigned rem;
    logic [OW-1:0] a, b, c;
    slots_o = '0;
    a       = '0;
    b       = '0;
    c       = '0;
    n       = 32'(n_i);
    ntri    = n / 3;
    rem     = n - 3 * ntri;
    for (int unsigned t = 0; t < N / 3; t++) begin
      if (t < ntri) begin
        a = slots_i[3*t];
        b = slots_i[3*t+1];
        c = slots_i[3*t+2];
        slots_o[2*t]   = a ^ b ^ c;
        slots_o[2*t+1] = ((a & b) | (a & c) | (b & c)) << 1;
      end
    end
    // Leftover slots are packed directly after the triple outputs.
    for (int unsigned r = 0; r < 2; r++) begin
      if (r < rem) slots_o[2*ntri+r] = slots_i[3*ntri+r];
    end
  end

endmodule

// File: rtl/csa_reduce_seq.sv
// Multi-cycle N-operand carry-save reducer: one 3:2 layer per clock, then a final add.
module csa_reduce_seq
  import csa_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned W      = 64,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned OW    = W + $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0][W-1:0]    in_ops,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_sum,
  output logic                   busy
);

  localparam int unsigned LAYERS = csa_layers(N);
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  csa_state_t           state_q;
  logic [N-1:0][OW-1:0] slot_q;
  logic [N-1:0][OW-1:0] slot_layer;
  logic [N-1:0][OW-1:0] slot_ld;
  logic [CW-1:0]        cnt_q;
  logic [LW-1:0]        layer_q;
  logic [OW-1:0]        sum_q;
  logic                 accept;

  csa_layer #(
    .N  (N),
    .OW (OW)
  ) u_layer (
    .slots_i (slot_q),
    .n_i     (cnt_q),
    .slots_o (slot_layer)
  );

  always_comb begin
    slot_ld = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SIGNED) slot_ld[i] = OW'($signed(in_ops[i]));
      else        slot_ld[i] = OW'(in_ops[i]);
    end
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == REDUCE) | (state_q == ADD);
  assign out_sum   = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      layer_q <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE doubles as an accept state so back-to-back sets lose no cycle.
          if (accept) begin
            slot_q  <= slot_ld;
            cnt_q   <= CW'(N);
            layer_q <= '0;
            state_q <= (LAYERS > 0) ? REDUCE : ADD;
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
        REDUCE: begin
          slot_q  <= slot_layer;
          cnt_q   <= CW'(csa_next(32'(cnt_q)));
          layer_q <= layer_q + 1'b1;
          if (32'(layer_q) == LAYERS - 1) state_q <= ADD;
        end
        ADD: begin
          sum_q   <= slot_q[0] + slot_q[1];
          state_q <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_reduce_seq.sv
// Bench for csa_reduce_seq over several N/W/SIGNED configurations against an arithmetic sum model.
module tb_csa_reduce_seq;

  localparam int NCFG = 6;

  function automatic int cfg_n(input int k);
    case (k)
      0: return 32;
      1: return 3;
      2: return 2;
      3: return 5;
      4: return 7;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_w(input int k);
    case (k)
      0: return 64;
      4: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic bit cfg_s(input int k);
    return (k == 2) || (k == 3) || (k == 4);
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid   [NCFG];
  logic          out_ready  [NCFG];
  logic [2047:0] ops        [NCFG];
  logic          in_ready_w [NCFG];
  logic          out_valid_w[NCFG];
  logic          busy_w     [NCFG];
  logic [127:0]  sum_w      [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GN  = cfg_n(g);
    localparam int GW  = cfg_w(g);
    localparam int GOW = GW + $clog2(GN);
    logic [GOW-1:0] s;
    logic ir, ov, bz;
    csa_reduce_seq #(
      .N      (GN),
      .W      (GW),
      .SIGNED (cfg_s(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (ir),
      .in_ops    (ops[g][GN*GW-1:0]),
      .out_valid (ov),
      .out_ready (out_ready[g]),
      .out_sum   (s),
      .busy      (bz)
    );
    assign sum_w[g]       = 128'(s);
    assign in_ready_w[g]  = ir;
    assign out_valid_w[g] = ov;
    assign busy_w[g]      = bz;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum of the extended operands, reduced modulo 2^OW.
  function automatic logic [127:0] ref_sum(input int k, input logic [2047:0] o);
    int n, w, ow;
    logic [2047:0] sh;
    logic [63:0]   u;
    logic [127:0]  v, acc;
    n   = cfg_n(k);
    w   = cfg_w(k);
    ow  = w;
    for (int t = 1; t < n; t = t * 2) ow++;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      sh = o >> (i * w);
      u  = sh[63:0];
      if (w < 64) u = u & ((64'd1 << w) - 64'd1);
      v = 128'(u);
      if (cfg_s(k) && u[w-1]) v = v - (128'd1 << w);
      acc = acc + v;
    end
    return acc & ((128'd1 << ow) - 128'd1);
  endfunction

  function automatic int exp_latency(input int n0);
    int n, l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l + 1;
  endfunction

  function automatic logic [2047:0] rand_ops(input int k);
    logic [2047:0] r;
    int mode;
    mode = $urandom_range(0, 5);
    r = '0;
    if (mode == 0) r = '1;
    else if (mode == 1) r = '0;
    else if (mode == 2) begin
      for (int i = 0; i < cfg_n(k); i++) r[i*cfg_w(k)+cfg_w(k)-1] = 1'b1;
    end else begin
      for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  // Call at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_one(input int k, input logic [2047:0] o, input bit ordy,
                         output int lat, output bit ir_seen);
    out_ready[k] = ordy;
    in_valid[k]  = 1'b1;
    ops[k]       = o;
    #1;
    check_eq("accept_ready", 128'(in_ready_w[k]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    lat     = 0;
    ir_seen = 1'b0;
    @(negedge clk);
    while (!out_valid_w[k] && lat < 200) begin
      if (in_ready_w[k]) ir_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic random_phase(input int k, input int txn);
    logic [127:0] q[$];
    int  sent, got, cyc;
    bit  pend;
    sent = 0;
    got  = 0;
    cyc  = 0;
    pend = 1'b0;
    while (got < txn && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready[k] = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if (sent < txn && $urandom_range(0, 2) != 0) begin
          ops[k]      = rand_ops(k);
          in_valid[k] = 1'b1;
          pend        = 1'b1;
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      #1;
      if (out_valid_w[k] && out_ready[k]) begin
        if (q.size() == 0) check_eq("rand_outstanding", 128'(q.size()), 128'd1);
        else check_eq("rand_sum", sum_w[k], q.pop_front());
        got++;
      end
      if (in_valid[k] && in_ready_w[k]) begin
        q.push_back(ref_sum(k, ops[k]));
        sent++;
        pend = 1'b0;
      end
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    check_eq("rand_count", 128'(got), 128'(txn));
    check_eq("rand_left", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit irs;
    logic [2047:0] o;
    logic [127:0] held;
    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      ops[k]       = '0;
    end
    #12;
    for (int k = 0; k < NCFG; k++) begin
      check_eq("rst_ctl", 128'({in_ready_w[k], out_valid_w[k], busy_w[k]}), 128'b100);
      check_eq("rst_sum", sum_w[k], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_one(0, '1, 1'b1, lat, irs);
    check_eq("n32_ones_lat", 128'(lat), 128'd9);
    check_eq("n32_ones_sum", sum_w[0], 128'h1F_FFFF_FFFF_FFFF_FFE0);

    o = '0;
    o[23:0] = {8'd50, 8'd100, 8'd200};
    run_one(1, o, 1'b1, lat, irs);
    check_eq("n3_lat", 128'(lat), 128'd2);
    check_eq("n3_sum", sum_w[1], 128'd350);
    check_eq("n3_busy_inready", 128'(irs), 128'd0);

    o = '0;
    o[15:0] = {8'hFF, 8'h80};
    run_one(2, o, 1'b1, lat, irs);
    check_eq("n2s_lat", 128'(lat), 128'd1);
    check_eq("n2s_sum", sum_w[2], 128'h17F);

    o = '0;
    o[39:0] = {8'hFB, 8'h04, 8'h03, 8'hFE, 8'hFF};
    run_one(3, o, 1'b1, lat, irs);
    check_eq("n5s_lat", 128'(lat), 128'(exp_latency(5)));
    check_eq("n5s_sum", sum_w[3], 128'h7FF);

    o = rand_ops(0);
    run_one(0, o, 1'b0, lat, irs);
    check_eq("bp_lat", 128'(lat), 128'd9);
    check_eq("bp_sum", sum_w[0], ref_sum(0, o));
    held = sum_w[0];
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_hold", 128'({out_valid_w[0], in_ready_w[0], sum_w[0][68:0]}),
               128'({2'b10, held[68:0]}));
    end
    for (int r = 0; r < 2; r++) begin
      o = rand_ops(0);
      run_one(0, o, 1'b1, lat, irs);
      check_eq("b2b_lat", 128'(lat), 128'd9);
      check_eq("b2b_sum", sum_w[0], ref_sum(0, o));
    end

    ops[0]      = rand_ops(0);
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_busy", 128'(busy_w[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ctl", 128'({in_ready_w[0], out_valid_w[0], busy_w[0]}), 128'b100);
    check_eq("midrst_sum", sum_w[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    o = rand_ops(0);
    run_one(0, o, 1'b1, lat, irs);
    check_eq("postrst_lat", 128'(lat), 128'd9);
    check_eq("postrst_sum", sum_w[0], ref_sum(0, o));

    for (int k = 0; k < NCFG; k++) random_phase(k, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
